// File: rtl/fetch_ibuffer_if.sv
// Handshake bundle between fetch, the per-warp instruction buffer and decode.
// The buffer connects through the slave modport; the fetch/decode side uses master.
interface fetch_ibuffer_if #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 30,
  parameter int INSTR_W     = 32,
  parameter int UUID_W      = 44
) ();
  localparam int NW_W = $clog2(NUM_WARPS);

  logic                   in_valid;
  logic [NW_W-1:0]        in_wid;
  logic [PC_BITS-1:0]     in_PC;
  logic [NUM_THREADS-1:0] in_tmask;
  logic [INSTR_W-1:0]     in_instr;
  logic [UUID_W-1:0]      in_uuid;
  logic                   in_ready;

  logic                   out_valid;
  logic [NW_W-1:0]        out_wid;
  logic [PC_BITS-1:0]     out_PC;
  logic [NUM_THREADS-1:0] out_tmask;
  logic [INSTR_W-1:0]     out_instr;
  logic [UUID_W-1:0]      out_uuid;
  logic                   out_ready;

  logic [NUM_WARPS-1:0]   ibuf_pop;

  modport slave (
    input  in_valid, in_wid, in_PC, in_tmask, in_instr, in_uuid, out_ready,
    output in_ready, out_valid, out_wid, out_PC, out_tmask, out_instr, out_uuid, ibuf_pop
  );

  modport master (
    output in_valid, in_wid, in_PC, in_tmask, in_instr, in_uuid, out_ready,
    input  in_ready, out_valid, out_wid, out_PC, out_tmask, out_instr, out_uuid, ibuf_pop
  );
endinterface

// File: rtl/fetch_ibuffer.sv
// Per-warp instruction FIFOs between fetch and decode, drained one instruction
// per cycle through a round-robin arbiter into a registered output stage.
module fetch_ibuffer #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int IBUF_SIZE   = 4,
  parameter int PC_BITS     = 30,
  parameter int INSTR_W     = 32,
  parameter int UUID_W      = 44
) (
  input  logic           clk,
  input  logic           reset,
  fetch_ibuffer_if.slave bus
);
  localparam int NW_W  = $clog2(NUM_WARPS);
  localparam int PTR_W = $clog2(IBUF_SIZE);
  localparam int ENT_W = PC_BITS + NUM_THREADS + INSTR_W + UUID_W;
  localparam int ADR_W = NW_W + PTR_W;

  // Storage for all warps in one array; the warp id forms the upper address bits.
  logic [ENT_W-1:0] mem_q [NUM_WARPS*IBUF_SIZE];

  logic [PTR_W:0] head_q [NUM_WARPS];
  logic [PTR_W:0] tail_q [NUM_WARPS];
  logic [PTR_W:0] head_d [NUM_WARPS];
  logic [PTR_W:0] tail_d [NUM_WARPS];

  logic [NUM_WARPS-1:0] empty;
  logic [NUM_WARPS-1:0] full;
  logic [NUM_WARPS-1:0] enq_w;
  logic [NUM_WARPS-1:0] deq_w;

  logic                   out_valid_q;
  logic [NW_W-1:0]        out_wid_q;
  logic [PC_BITS-1:0]     out_pc_q;
  logic [NUM_THREADS-1:0] out_tmask_q;
  logic [INSTR_W-1:0]     out_instr_q;
  logic [UUID_W-1:0]      out_uuid_q;
  logic [NW_W-1:0]        last_grant_q;

  logic            enq;
  logic            load;
  logic            grant_valid;
  logic [NW_W-1:0] grant_wid;
  logic [NW_W-1:0] cand;
  logic [ADR_W-1:0] wr_addr;
  logic [ADR_W-1:0] rd_addr;
  logic [NUM_WARPS-1:0] pop;

  assign bus.in_ready = ~full[bus.in_wid];
  assign enq          = bus.in_valid && bus.in_ready;
  assign load         = (~out_valid_q || bus.out_ready) && grant_valid;

  assign wr_addr = {bus.in_wid, tail_q[bus.in_wid][PTR_W-1:0]};
  assign rd_addr = {grant_wid, head_q[grant_wid][PTR_W-1:0]};

  generate
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      assign empty[gi] = (head_q[gi] == tail_q[gi]);
      assign full[gi]  = (head_q[gi][PTR_W-1:0] == tail_q[gi][PTR_W-1:0]) &&
                         (head_q[gi][PTR_W] != tail_q[gi][PTR_W]);
      assign enq_w[gi] = enq && (bus.in_wid == NW_W'(gi));
      assign deq_w[gi] = load && (grant_wid == NW_W'(gi));
      assign tail_d[gi] = tail_q[gi] + (PTR_W+1)'(enq_w[gi]);
      assign head_d[gi] = head_q[gi] + (PTR_W+1)'(deq_w[gi]);
    end
  endgenerate

  // Search starts one past the last grant; k == NUM_WARPS wraps back to it.
  always_comb begin
    grant_valid = 1'b0;
    grant_wid   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      cand = last_grant_q + NW_W'(k);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_wid   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_addr] <= {bus.in_PC, bus.in_tmask, bus.in_instr, bus.in_uuid};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        head_q[w] <= '0;
        tail_q[w] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_wid_q    <= '0;
      out_pc_q     <= '0;
      out_tmask_q  <= '0;
      out_instr_q  <= '0;
      out_uuid_q   <= '0;
      last_grant_q <= NW_W'(NUM_WARPS - 1);
    end else if (load) begin
      out_valid_q  <= 1'b1;
      out_wid_q    <= grant_wid;
      {out_pc_q, out_tmask_q, out_instr_q, out_uuid_q} <= mem_q[rd_addr];
      last_grant_q <= grant_wid;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  // Suppressed during reset so instructions being discarded never report a pop.
  always_comb begin
    pop = '0;
    if (out_valid_q && bus.out_ready && !reset) begin
      pop[out_wid_q] = 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_wid   = out_wid_q;
  assign bus.out_PC    = out_pc_q;
  assign bus.out_tmask = out_tmask_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_uuid  = out_uuid_q;
  assign bus.ibuf_pop  = pop;

  a_wid_range: assert property (@(posedge clk) disable iff (reset)
    bus.in_valid |-> (int'(bus.in_wid) < NUM_WARPS));
  a_no_full_enq: assert property (@(posedge clk) disable iff (reset)
    !(enq && full[bus.in_wid]));
endmodule

// File: tb/tb_fetch_ibuffer.sv
// Directed bench for fetch_ibuffer: latency, fill/order, round-robin,
// full-refusal, backpressure and mid-operation reset.
module tb_fetch_ibuffer;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_ibuffer_if bus ();

  fetch_ibuffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] wid, input logic [29:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_wid   = wid;
    bus.in_PC    = pc;
    bus.in_tmask = 4'hF;
    bus.in_instr = instr;
    bus.in_uuid  = 44'(pc);
    tick();
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_wid = '0; bus.in_PC = '0; bus.in_tmask = '0; bus.in_instr = '0; bus.in_uuid = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.out_valid); end
    checks++;
    if (bus.ibuf_pop !== 4'b0000) begin errors++; $display("FAIL rst_pop: got %b want 0000", bus.ibuf_pop); end
    for (int w = 0; w < 4; w++) begin
      bus.in_wid = 2'(w);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready wid=%0d: got %0b want 1", w, bus.in_ready); end
    end
  endtask

  task automatic test_latency;
    bus.out_ready = 1'b1;
    push(2'd2, 30'h100, 32'h13);   // write edge
    tick();                        // load edge
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %0b want 1", bus.out_valid); end
    checks++;
    if (bus.out_wid !== 2'd2) begin errors++; $display("FAIL lat_wid: got %0d want 2", bus.out_wid); end
    checks++;
    if (bus.out_PC !== 30'h100) begin errors++; $display("FAIL lat_pc: got %h want 100", bus.out_PC); end
    checks++;
    if (bus.out_instr !== 32'h13) begin errors++; $display("FAIL lat_instr: got %h want 13", bus.out_instr); end
    checks++;
    if (bus.ibuf_pop !== 4'b0100) begin errors++; $display("FAIL lat_pop: got %b want 0100", bus.ibuf_pop); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_clear: got %0b want 0", bus.out_valid); end
    checks++;
    if (bus.ibuf_pop !== 4'b0000) begin errors++; $display("FAIL lat_pop_clear: got %b want 0000", bus.ibuf_pop); end
  endtask

  // Five pushes: the first moves into the idle output register, four fill the FIFO.
  task automatic test_fill;
    int pops;
    pops = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(2'd1, 30'h10 + 30'(i), 32'hA000 + 32'(i));
    bus.in_wid = 2'd1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_w1: got %0b want 0", bus.in_ready); end
    bus.in_wid = 2'd0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_free_w0: got %0b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_PC !== 30'h10 + 30'(i))
        begin errors++; $display("FAIL fill_order[%0d]: got v=%0b pc=%h want v=1 pc=%h", i, bus.out_valid, bus.out_PC, 30'h10 + 30'(i)); end
      checks++;
      if (bus.ibuf_pop !== 4'b0010) begin errors++; $display("FAIL fill_pop[%0d]: got %b want 0010", i, bus.ibuf_pop); end
      if (bus.ibuf_pop == 4'b0010) pops++;
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_drained: got %0b want 0", bus.out_valid); end
    checks++;
    if (pops != 5) begin errors++; $display("FAIL fill_pop_count: got %0d want 5", pops); end
  endtask

  task automatic test_round_robin;
    logic [1:0] ord [4];
    logic [1:0] exp [4];
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin ord = '{2'd0, 2'd1, 2'd2, 2'd3}; exp = '{2'd0, 2'd1, 2'd2, 2'd3}; end
      else        begin ord = '{2'd2, 2'd0, 2'd3, 2'd1}; exp = '{2'd2, 2'd3, 2'd0, 2'd1}; end
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(ord[i], 30'h200 + 30'(16 * r) + 30'(ord[i]), 32'h0);
      bus.out_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_wid !== exp[i])
          begin errors++; $display("FAIL rr%0d_wid[%0d]: got v=%0b wid=%0d want v=1 wid=%0d", r, i, bus.out_valid, bus.out_wid, exp[i]); end
        checks++;
        if (bus.out_PC !== 30'h200 + 30'(16 * r) + 30'(exp[i]))
          begin errors++; $display("FAIL rr%0d_pc[%0d]: got %h want %h", r, i, bus.out_PC, 30'h200 + 30'(16 * r) + 30'(exp[i])); end
        tick();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr%0d_drained: got %0b want 0", r, bus.out_valid); end
    end
  endtask

  task automatic test_full_same_cycle;
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(2'd3, 30'h300 + 30'(i), 32'h0);
    checks++;
    if (bus.out_PC !== 30'h300) begin errors++; $display("FAIL full_head: got %h want 300", bus.out_PC); end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_wid = 2'd3; bus.in_PC = 30'h305; bus.in_instr = 32'h0; bus.in_uuid = 44'h305;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_refuse: got %0b want 0", bus.in_ready); end
    checks++;
    if (bus.ibuf_pop !== 4'b1000) begin errors++; $display("FAIL full_pop: got %b want 1000", bus.ibuf_pop); end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_accept_next: got %0b want 1", bus.in_ready); end
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_again: got %0b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_PC !== 30'h300 + 30'(i))
        begin errors++; $display("FAIL full_drain[%0d]: got v=%0b pc=%h want v=1 pc=%h", i, bus.out_valid, bus.out_PC, 30'h300 + 30'(i)); end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure;
    logic        rdy [4];
    logic [29:0] pc  [4];
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
    pc  = '{30'h400, 30'h401, 30'h401, 30'h401};
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(2'd0, 30'h400 + 30'(i), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = rdy[i];
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_PC !== pc[i])
        begin errors++; $display("FAIL bp_pc[%0d]: got v=%0b pc=%h want v=1 pc=%h", i, bus.out_valid, bus.out_PC, pc[i]); end
      checks++;
      if (bus.ibuf_pop !== (rdy[i] ? 4'b0001 : 4'b0000))
        begin errors++; $display("FAIL bp_pop[%0d]: got %b want %b", i, bus.ibuf_pop, rdy[i] ? 4'b0001 : 4'b0000); end
      tick();
    end
    checks++;
    if (bus.out_PC !== 30'h402) begin errors++; $display("FAIL bp_last: got %h want 402", bus.out_PC); end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    push(2'd1, 30'h500, 32'h0);
    push(2'd2, 30'h501, 32'h0);
    push(2'd3, 30'h502, 32'h0);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.ibuf_pop !== 4'b0000) begin errors++; $display("FAIL mid_pop_in_reset: got %b want 0000", bus.ibuf_pop); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", bus.out_valid); end
    for (int w = 0; w < 4; w++) begin
      bus.in_wid = 2'(w);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready wid=%0d: got %0b want 1", w, bus.in_ready); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ibuf_pop !== 4'b0000)
        begin errors++; $display("FAIL mid_quiet[%0d]: got v=%0b pop=%b want v=0 pop=0000", i, bus.out_valid, bus.ibuf_pop); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_round_robin();
    test_full_same_cycle();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
